// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core: jump-control encodings and the
// default reset, exception and fetch-window addresses.
package mips_pkg;

  typedef enum logic [1:0] {
    JC_SEQ = 2'b00,
    JC_J   = 2'b01,
    JC_JR  = 2'b10
  } j_ctrl_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_BYTES = 32'h0000_4000;

endpackage

// File: rtl/pc_unit_if.sv
// Control, redirect and fetch-port signals between the D/M hazard logic,
// the PC unit and the instruction-memory port.
interface pc_unit_if;
  logic        stall;
  logic        f_ready;
  logic [31:0] d_pc;
  logic [31:0] d_offset;
  logic [25:0] d_imm26;
  logic [31:0] d_ra;
  logic [1:0]  j_ctrl;
  logic        d_is_branch;
  logic        cmp_out;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] f_pc;
  logic        f_adel;
  logic        redirect_pending;

  modport master (
    output stall, f_ready, d_pc, d_offset, d_imm26, d_ra, j_ctrl,
           d_is_branch, cmp_out, exc_req, eret_req, epc,
    input  f_pc, f_adel, redirect_pending
  );

  modport slave (
    input  stall, f_ready, d_pc, d_offset, d_imm26, d_ra, j_ctrl,
           d_is_branch, cmp_out, exc_req, eret_req, epc,
    output f_pc, f_adel, redirect_pending
  );
endinterface

// File: rtl/pc_target.sv
// Combinational redirect decision and target address for the instruction in D.
module pc_target
  import mips_pkg::*;
(
  input  logic [31:0] d_pc,
  input  logic [31:0] d_offset,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_ra,
  input  logic [1:0]  j_ctrl,
  input  logic        d_is_branch,
  input  logic        cmp_out,
  output logic        d_redir,
  output logic [31:0] target
);

  logic [31:0] seq_pc;

  assign seq_pc = d_pc + 32'd4;

  // Encoding 11 falls into the default arm and behaves like sequential/branch.
  always_comb begin
    d_redir = 1'b0;
    target  = seq_pc + d_offset;
    case (j_ctrl)
      JC_J: begin
        d_redir = 1'b1;
        target  = {seq_pc[31:28], d_imm26, 2'b00};
      end
      JC_JR: begin
        d_redir = 1'b1;
        target  = d_ra;
      end
      default: d_redir = d_is_branch & cmp_out;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC register with exception/eret entry, hazard stall and a
// one-entry pending-redirect buffer covering instruction-memory back-pressure.
module pc_unit #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] EXC_PC   = mips_pkg::EXC_PC,
  parameter logic [31:0] IM_BASE  = mips_pkg::IM_BASE,
  parameter logic [31:0] IM_BYTES = mips_pkg::IM_BYTES
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] pend_pc_reg, pend_pc_next;
  logic        pend_valid_reg, pend_valid_next;
  logic        d_redir;
  logic [31:0] d_target;
  logic        adv;
  logic [32:0] pc_ext, win_lo, win_hi;

  pc_target u_target (
    .d_pc        (bus.d_pc),
    .d_offset    (bus.d_offset),
    .d_imm26     (bus.d_imm26),
    .d_ra        (bus.d_ra),
    .j_ctrl      (bus.j_ctrl),
    .d_is_branch (bus.d_is_branch),
    .cmp_out     (bus.cmp_out),
    .d_redir     (d_redir),
    .target      (d_target)
  );

  assign adv = !bus.stall && bus.f_ready;

  always_comb begin
    pc_next         = pc_reg;
    pend_pc_next    = pend_pc_reg;
    pend_valid_next = pend_valid_reg;
    if (bus.exc_req) begin
      pc_next         = EXC_PC;
      pend_valid_next = 1'b0;
    end else if (bus.eret_req) begin
      pc_next         = bus.epc;
      pend_valid_next = 1'b0;
    end else if (bus.stall) begin
      // D is re-presented after the stall, so its redirect is picked up then.
    end else if (adv) begin
      if (d_redir)             pc_next = d_target;
      else if (pend_valid_reg) pc_next = pend_pc_reg;
      else                     pc_next = pc_reg + 32'd4;
      pend_valid_next = 1'b0;
    end else if (d_redir && !pend_valid_reg) begin
      // A second redirect while one is parked is a branch in a delay slot; keep the first.
      pend_pc_next    = d_target;
      pend_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg         <= RESET_PC;
      pend_pc_reg    <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      pend_pc_reg    <= pend_pc_next;
      pend_valid_reg <= pend_valid_next;
    end
  end

  // 33-bit compare so IM_BASE + IM_BYTES cannot wrap to a small value.
  assign pc_ext = {1'b0, pc_reg};
  assign win_lo = {1'b0, IM_BASE};
  assign win_hi = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

  assign bus.f_pc             = pc_reg;
  assign bus.f_adel           = (pc_reg[1:0] != 2'b00) || (pc_ext < win_lo) || (pc_ext >= win_hi);
  assign bus.redirect_pending = pend_valid_reg;

endmodule

// File: doc/pc_unit.md
# pc_unit

Fetch-stage program-counter unit: owns the PC register and computes the next PC for the pipelined MIPS core. It is the successor to the combinational next-PC selector. It adds a parametrised reset, exception and fetch-range map, hazard stall, exception entry and `eret` return, and a fetch-ready handshake. The handshake is backed by a one-entry pending-redirect buffer, so a branch or jump resolved in D is never lost while instruction memory is busy. It sits between the hazard/control logic in D/M and the instruction-memory port in F.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC loaded on reset.
- `EXC_PC`, 32'h0000_4180, exception handler entry.
- `IM_BASE`, 32'h0000_3000, lowest legal fetch address.
- `IM_BYTES`, 32'h0000_4000, size of the legal fetch window in bytes.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard freeze of F and D.
- `f_ready` in 1: instruction memory accepts `f_pc` this cycle.
- `d_pc` in 32: PC of the instruction in D.
- `d_offset` in 32: sign-extended branch offset, already multiplied by 4.
- `d_imm26` in 26: jump index.
- `d_ra` in 32: forwarded `rs` value for `jr`/`jalr`.
- `j_ctrl` in 2: 00 = branch/sequential, 01 = `j`/`jal`, 10 = `jr`/`jalr`, 11 = treated as 00.
- `d_is_branch` in 1: the D instruction is a conditional branch.
- `cmp_out` in 1: branch condition is true.
- `exc_req` in 1: exception taken in M.
- `eret_req` in 1: `eret` in M.
- `epc` in 32: return address for `eret`.
- `f_pc` out 32: current fetch PC (registered).
- `f_adel` out 1: `f_pc` is misaligned or outside [IM_BASE, IM_BASE+IM_BYTES).
- `redirect_pending` out 1: the pending buffer is valid.

## Operation
- Redirect request: `d_redir = (j_ctrl==01) | (j_ctrl==10) | (j_ctrl[1]==j_ctrl[0] & d_is_branch & cmp_out)`.
- Target selection:
  - Branch: `d_pc + 4 + d_offset`, mod 2^32.
  - 01: `{(d_pc+4)[31:28], d_imm26, 2'b00}`.
  - 10: `d_ra` unmodified. A misaligned target is loaded and reported by `f_adel`; the block does not trap.
- Branch delay slot is architectural: when the redirect fires, `f_pc` already points at the delay slot. The target becomes the PC after the delay slot is fetched.
- Define `adv = !stall & f_ready`.
- Per-cycle priority, highest first:
  1. `reset`: `f_pc <= RESET_PC`, pending cleared.
  2. `exc_req`: `f_pc <= EXC_PC`, pending cleared. This ignores `stall` and `f_ready`.
  3. `eret_req`: `f_pc <= epc`, pending cleared. This ignores `stall` and `f_ready`.
  4. `stall`: hold `f_pc` and the pending buffer. `d_redir` is ignored because D is re-presented next cycle.
  5. `adv`: `f_pc <=` target if `d_redir`; else the pending PC if pending is valid; else `f_pc + 4`. Pending is cleared.
  6. `!stall & !f_ready`: hold `f_pc`. If `d_redir` and pending is not valid, capture the target into the pending buffer.
- A new `d_redir` while pending is valid is ISA-illegal (branch in delay slot). The first captured target is retained and the new one is dropped.
- `f_adel` is combinational from `f_pc` only. It is asserted when `f_pc[1:0]!=0`, when `f_pc < IM_BASE`, or when `f_pc >= IM_BASE+IM_BYTES`. The comparison uses unsigned 33-bit arithmetic so the window end cannot wrap.

## Timing
- Reset values: `f_pc = RESET_PC`, `redirect_pending = 0`, `f_adel = 0` with the default parameters.
- Redirect latency: a redirect presented in cycle N with `adv` appears on `f_pc` at N+1.
- Exception and `eret` latency: 1 cycle.
- Pending buffer latency: the captured target appears on `f_pc` one cycle after the first subsequent `adv` cycle.
- `f_pc + 4` wraps mod 2^32 with no flag beyond `f_adel`.
- `exc_req` and `eret_req` asserted together: the exception wins.
- `reset` during a pending redirect: the pending buffer is discarded.

## Structure
- Shared package `mips_pkg` holds:
  - the `j_ctrl` encodings `JC_SEQ`, `JC_J`, `JC_JR`;
  - the default address constants `RESET_PC`, `EXC_PC`, `IM_BASE`, `IM_BYTES`.
- One sub-module, `pc_target`: purely combinational `d_redir` and target computation.
- The registers, priority logic and pending buffer stay in `pc_unit`.

## Test plan
- Reset, then 3 cycles with `f_ready=1` -> `f_pc` = 3000, 3004, 3008, 300C; `f_adel=0`.
- At `d_pc=3008`, `f_pc=300C`: `d_is_branch=1`, `cmp_out=1`, `d_offset=32'hFFFF_FFF0` -> next `f_pc=32'h0000_2FFC`, `f_adel=1`.
- `f_pc=3010`, `f_ready=0`: `j_ctrl=01`, `d_pc=300C`, `d_imm26=26'h0000C40` -> `f_pc` holds at 3010 and `redirect_pending=1`. After `f_ready` returns to 1 -> `f_pc=3100`, `redirect_pending=0`.
- `stall=1` with `j_ctrl=10` and `d_ra=3400`, then `stall=0` -> `f_pc` holds during the stall and becomes 3400 the cycle after release.
- `stall=1`, `f_ready=0`, `exc_req=1` -> next `f_pc=4180`. Same cycle with `eret_req=1` also asserted -> 4180 (exception wins). Later `eret_req=1`, `epc=3020` -> 3020.
- `j_ctrl=10`, `d_ra=3402` -> `f_pc=3402`, `f_adel=1`. Pending is valid and `reset` is asserted -> `f_pc=3000`, `redirect_pending=0`.
